color_classifier_seq: RTL and testbench

COLOR_CLASSIFIER_SEQ -- requirements
Module: color_classifier_seq

---
 rtl/color_pkg.sv | 32 +++
 rtl/color_accumulator.sv | 35 +++
 rtl/color_classifier_seq.sv | 157 +++++++++++++++
 tb/tb_color_classifier_seq.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/color_pkg.sv
// Shared definitions for the colour classifier: classification codes, their
// ASCII representation and the sequencer state encoding.
package color_pkg;

  typedef enum logic [1:0] {
    ST_ACCUM    = 2'd0,
    ST_CLASSIFY = 2'd1,
    ST_EMIT     = 2'd2
  } state_t;

  localparam logic [1:0] CODE_UNDEF = 2'b00;
  localparam logic [1:0] CODE_RED   = 2'b01;
  localparam logic [1:0] CODE_GREEN = 2'b10;
  localparam logic [1:0] CODE_BLUE  = 2'b11;

  localparam logic [7:0] ASCII_X = 8'h58;
  localparam logic [7:0] ASCII_R = 8'h52;
  localparam logic [7:0] ASCII_G = 8'h47;
  localparam logic [7:0] ASCII_B = 8'h42;

  function automatic logic [7:0] code_to_ascii(input logic [1:0] code);
    logic [7:0] a;
    case (code)
      CODE_RED:   a = ASCII_R;
      CODE_GREEN: a = ASCII_G;
      CODE_BLUE:  a = ASCII_B;
      default:    a = ASCII_X;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/color_accumulator.sv
// Single-channel sample accumulator.
//   clk, rst  : clock, asynchronous active-high reset
//   accept    : a sample is taken this edge
//   last      : the accepted sample completes the group; accumulator clears
//   din       : channel sample
//   sum_next  : running sum including din (valid to capture on the last edge)
module color_accumulator #(
  parameter int DATA_W   = 16,
  parameter int AVG_LOG2 = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         accept,
  input  logic                         last,
  input  logic [DATA_W-1:0]            din,
  output logic [DATA_W+AVG_LOG2-1:0]   sum_next
);
  import color_pkg::*;

  localparam int ACC_W = DATA_W + AVG_LOG2;

  logic [ACC_W-1:0] acc;

  // ACC_W holds 2^AVG_LOG2 full-scale samples, so this cannot overflow.
  assign sum_next = acc + ACC_W'(din);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (accept) begin
      acc <= last ? '0 : sum_next;
    end
  end

endmodule

// File: rtl/color_classifier_seq.sv
// Averages 2^AVG_LOG2 RGB samples, classifies the dominant colour, emits the
// code and its ASCII letter, and counts new objects per colour.
//   clk, rst                 : clock, asynchronous active-high reset
//   sample_valid/ready       : sample handshake (ready only while accumulating)
//   red, green, blue         : channel samples
//   clear_counts             : synchronous clear of the object counters
//   color_code, code_valid   : last classification, one-cycle pulse when new
//   ascii_color/valid/ready  : ASCII letter of the code with handshake
//   cnt_red/green/blue       : saturating per-colour object counters
module color_classifier_seq #(
  parameter int DATA_W   = 16,
  parameter int AVG_LOG2 = 2,
  parameter int MARGIN   = 32,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic [DATA_W-1:0] red,
  input  logic [DATA_W-1:0] green,
  input  logic [DATA_W-1:0] blue,
  input  logic              clear_counts,
  output logic [1:0]        color_code,
  output logic              code_valid,
  output logic [7:0]        ascii_color,
  output logic              ascii_valid,
  input  logic              ascii_ready,
  output logic [CNT_W-1:0]  cnt_red,
  output logic [CNT_W-1:0]  cnt_green,
  output logic [CNT_W-1:0]  cnt_blue
);
  import color_pkg::*;

  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int N     = 1 << AVG_LOG2;
  localparam int SC_W  = AVG_LOG2 + 1;
  localparam int CMP_W = DATA_W + 1;

  state_t            state, state_nxt;
  logic [SC_W-1:0]   sample_cnt;
  logic              accept, last;
  logic [ACC_W-1:0]  nxt_r, nxt_g, nxt_b;
  logic [ACC_W-1:0]  sum_r, sum_g, sum_b;
  logic [DATA_W-1:0] avg_r, avg_g, avg_b;
  logic [CMP_W-1:0]  ext_r, ext_g, ext_b;
  logic [1:0]        class_code;
  logic              new_obj;

  assign sample_ready = (state == ST_ACCUM);
  assign accept       = sample_valid & sample_ready;
  assign last         = (sample_cnt == SC_W'(N - 1));

  color_accumulator #(.DATA_W(DATA_W), .AVG_LOG2(AVG_LOG2)) u_acc_red (
    .clk(clk), .rst(rst), .accept(accept), .last(last), .din(red), .sum_next(nxt_r)
  );
  color_accumulator #(.DATA_W(DATA_W), .AVG_LOG2(AVG_LOG2)) u_acc_green (
    .clk(clk), .rst(rst), .accept(accept), .last(last), .din(green), .sum_next(nxt_g)
  );
  color_accumulator #(.DATA_W(DATA_W), .AVG_LOG2(AVG_LOG2)) u_acc_blue (
    .clk(clk), .rst(rst), .accept(accept), .last(last), .din(blue), .sum_next(nxt_b)
  );

  // Sample counter and capture of the completed group sums.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_cnt <= '0;
      sum_r      <= '0;
      sum_g      <= '0;
      sum_b      <= '0;
    end else if (accept) begin
      if (last) begin
        sample_cnt <= '0;
        sum_r      <= nxt_r;
        sum_g      <= nxt_g;
        sum_b      <= nxt_b;
      end else begin
        sample_cnt <= sample_cnt + 1'b1;
      end
    end
  end

  // Averages widened by one bit so adding MARGIN never wraps.
  always_comb begin
    avg_r = DATA_W'(sum_r >> AVG_LOG2);
    avg_g = DATA_W'(sum_g >> AVG_LOG2);
    avg_b = DATA_W'(sum_b >> AVG_LOG2);
    ext_r = {1'b0, avg_r};
    ext_g = {1'b0, avg_g};
    ext_b = {1'b0, avg_b};
    class_code = CODE_UNDEF;
    if ((ext_r > ext_g + CMP_W'(MARGIN)) && (ext_r > ext_b + CMP_W'(MARGIN)))
      class_code = CODE_RED;
    else if ((ext_g > ext_r + CMP_W'(MARGIN)) && (ext_g > ext_b + CMP_W'(MARGIN)))
      class_code = CODE_GREEN;
    else if ((ext_b > ext_r + CMP_W'(MARGIN)) && (ext_b > ext_g + CMP_W'(MARGIN)))
      class_code = CODE_BLUE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_ACCUM;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_ACCUM:    if (accept && last) state_nxt = ST_CLASSIFY;
      ST_CLASSIFY: state_nxt = ST_EMIT;
      ST_EMIT:     if (ascii_ready) state_nxt = ST_ACCUM;
      default:     state_nxt = ST_ACCUM;
    endcase
  end

  // color_code doubles as the previous registered code for object detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      color_code  <= CODE_UNDEF;
      ascii_color <= ASCII_X;
      code_valid  <= 1'b0;
      ascii_valid <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      if (state == ST_CLASSIFY) begin
        color_code  <= class_code;
        ascii_color <= code_to_ascii(class_code);
        code_valid  <= 1'b1;
        ascii_valid <= 1'b1;
      end else if (state == ST_EMIT && ascii_ready) begin
        ascii_valid <= 1'b0;
      end
    end
  end

  assign new_obj = (state == ST_CLASSIFY) && (class_code != CODE_UNDEF) &&
                   (class_code != color_code);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_red   <= '0;
      cnt_green <= '0;
      cnt_blue  <= '0;
    end else if (clear_counts) begin
      cnt_red   <= '0;
      cnt_green <= '0;
      cnt_blue  <= '0;
    end else if (new_obj) begin
      case (class_code)
        CODE_RED:   if (cnt_red   != '1) cnt_red   <= cnt_red   + 1'b1;
        CODE_GREEN: if (cnt_green != '1) cnt_green <= cnt_green + 1'b1;
        CODE_BLUE:  if (cnt_blue  != '1) cnt_blue  <= cnt_blue  + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_color_classifier_seq.sv
module tb_color_classifier_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_valid = 1'b0;
  logic [15:0] red = '0, green = '0, blue = '0;
  logic        clear_counts = 1'b0;
  logic        ascii_ready = 1'b1;

  logic        sample_ready_a, code_valid_a, ascii_valid_a;
  logic [1:0]  color_code_a;
  logic [7:0]  ascii_color_a;
  logic [7:0]  cnt_red_a, cnt_green_a, cnt_blue_a;

  logic        sample_ready_b, code_valid_b, ascii_valid_b;
  logic [1:0]  color_code_b;
  logic [7:0]  ascii_color_b;
  logic [1:0]  cnt_red_b, cnt_green_b, cnt_blue_b;

  int checks = 0;
  int errors = 0;

  int sr[4], sg[4], sb[4];
  int m8[4], m2[4];
  int mprev;

  always #5 clk = ~clk;

  color_classifier_seq #(.DATA_W(16), .AVG_LOG2(2), .MARGIN(32), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_ready(sample_ready_a),
    .red(red), .green(green), .blue(blue), .clear_counts(clear_counts),
    .color_code(color_code_a), .code_valid(code_valid_a), .ascii_color(ascii_color_a),
    .ascii_valid(ascii_valid_a), .ascii_ready(ascii_ready),
    .cnt_red(cnt_red_a), .cnt_green(cnt_green_a), .cnt_blue(cnt_blue_a)
  );

  color_classifier_seq #(.DATA_W(16), .AVG_LOG2(2), .MARGIN(32), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_ready(sample_ready_b),
    .red(red), .green(green), .blue(blue), .clear_counts(clear_counts),
    .color_code(color_code_b), .code_valid(code_valid_b), .ascii_color(ascii_color_b),
    .ascii_valid(ascii_valid_b), .ascii_ready(ascii_ready),
    .cnt_red(cnt_red_b), .cnt_green(cnt_green_b), .cnt_blue(cnt_blue_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: truncated integer averages, strict dominance by the margin.
  function automatic int model_code();
    int ar, ag, ab;
    ar = (sr[0] + sr[1] + sr[2] + sr[3]) / 4;
    ag = (sg[0] + sg[1] + sg[2] + sg[3]) / 4;
    ab = (sb[0] + sb[1] + sb[2] + sb[3]) / 4;
    if (ar > ag + 32 && ar > ab + 32) return 1;
    if (ag > ar + 32 && ag > ab + 32) return 2;
    if (ab > ar + 32 && ab > ag + 32) return 3;
    return 0;
  endfunction

  function automatic int exp_ascii(input int code);
    case (code)
      1: return 82;
      2: return 71;
      3: return 66;
      default: return 88;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m8[i] = 0;
      m2[i] = 0;
    end
    mprev = 0;
  endtask

  task automatic set_all(input int r, input int g, input int b);
    for (int i = 0; i < 4; i++) begin
      sr[i] = r; sg[i] = g; sb[i] = b;
    end
  endtask

  task automatic check_counts();
    chk("cnt_red",       32'(cnt_red_a),   m8[1]);
    chk("cnt_green",     32'(cnt_green_a), m8[2]);
    chk("cnt_blue",      32'(cnt_blue_a),  m8[3]);
    chk("sat_cnt_red",   32'(cnt_red_b),   m2[1]);
    chk("sat_cnt_green", 32'(cnt_green_b), m2[2]);
    chk("sat_cnt_blue",  32'(cnt_blue_b),  m2[3]);
  endtask

  task automatic check_reset_outputs();
    chk("rst_code",        32'(color_code_a),  0);
    chk("rst_ascii",       32'(ascii_color_a), 88);
    chk("rst_code_valid",  32'(code_valid_a),  0);
    chk("rst_ascii_valid", 32'(ascii_valid_a), 0);
    chk("rst_ready",       32'(sample_ready_a), 1);
    check_counts();
  endtask

  // Feed the 4 samples in sr/sg/sb, hold ascii_ready low for `hold` EMIT
  // cycles while offering junk samples, optionally pulse clear_counts on
  // the same edge that registers the new code.
  task automatic run_group(input int hold, input bit clr);
    int code;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("ready_accum", 32'(sample_ready_a), 1);
      sample_valid = 1'b1;
      red = 16'(sr[i]); green = 16'(sg[i]); blue = 16'(sb[i]);
    end
    @(negedge clk);
    sample_valid = 1'b0;
    chk("classify_no_pulse", 32'(code_valid_a), 0);
    chk("classify_not_ready", 32'(sample_ready_a), 0);
    ascii_ready = (hold == 0);
    clear_counts = clr;
    @(negedge clk);
    clear_counts = 1'b0;
    code = model_code();
    if (clr) begin
      for (int i = 0; i < 4; i++) begin
        m8[i] = 0;
        m2[i] = 0;
      end
    end else if (code != 0 && code != mprev) begin
      if (m8[code] < 255) m8[code]++;
      if (m2[code] < 3) m2[code]++;
    end
    mprev = code;
    chk("code_valid_pulse", 32'(code_valid_a), 1);
    chk("color_code", 32'(color_code_a), code);
    chk("ascii_color", 32'(ascii_color_a), exp_ascii(code));
    chk("ascii_valid", 32'(ascii_valid_a), 1);
    chk("sat_color_code", 32'(color_code_b), code);
    check_counts();
    for (int h = 0; h < hold; h++) begin
      sample_valid = 1'b1;
      red = 16'($urandom_range(0, 65535));
      green = 16'($urandom_range(0, 65535));
      blue = 16'($urandom_range(0, 65535));
      @(negedge clk);
      chk("hold_ascii_valid", 32'(ascii_valid_a), 1);
      chk("hold_ascii_color", 32'(ascii_color_a), exp_ascii(code));
      chk("hold_code_valid", 32'(code_valid_a), 0);
      chk("hold_not_ready", 32'(sample_ready_a), 0);
    end
    sample_valid = 1'b0;
    ascii_ready = 1'b1;
    @(negedge clk);
    chk("done_ascii_valid", 32'(ascii_valid_a), 0);
    chk("done_code_valid", 32'(code_valid_a), 0);
    chk("done_ready", 32'(sample_ready_a), 1);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 32'(sample_ready_a), 1);

    // Red object, then the same object again: counted once.
    set_all(300, 100, 100); run_group(0, 1'b0);
    chk("red_once", 32'(cnt_red_a), 1);
    set_all(300, 100, 100); run_group(0, 1'b0);
    chk("red_repeat", 32'(cnt_red_a), 1);

    // Grey is undefined, then green.
    set_all(200, 200, 200); run_group(0, 1'b0);
    set_all(100, 300, 100); run_group(0, 1'b0);
    chk("green_once", 32'(cnt_green_a), 1);

    // Margin boundary: exactly +32 is not dominant, +33 is.
    set_all(132, 100, 100); run_group(0, 1'b0);
    chk("margin_eq", 32'(color_code_a), 0);
    set_all(133, 100, 100); run_group(0, 1'b0);
    chk("margin_gt", 32'(color_code_a), 1);

    // Backpressure: junk offered during EMIT must not leak into the next group.
    set_all(100, 100, 300); run_group(5, 1'b0);
    set_all(100, 300, 100); run_group(0, 1'b0);
    chk("after_bp_green", 32'(color_code_a), 2);

    // Blue / undefined alternation saturates the 2-bit counter.
    for (int k = 0; k < 5; k++) begin
      set_all(100, 100, 300); run_group(0, 1'b0);
      set_all(200, 200, 200); run_group(0, 1'b0);
    end
    chk("sat_blue_3", 32'(cnt_blue_b), 3);
    set_all(100, 100, 300); run_group(0, 1'b1);
    chk("clear_wins", 32'(cnt_blue_b), 0);

    // Reset after two red-heavy samples discards them.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      sample_valid = 1'b1;
      red = 16'd60000; green = 16'd0; blue = 16'd0;
    end
    @(negedge clk);
    sample_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_rst2", 32'(sample_ready_a), 1);
    set_all(100, 100, 300); run_group(0, 1'b0);
    chk("post_rst_blue", 32'(color_code_a), 3);
    chk("post_rst_cnt", 32'(cnt_blue_a), 1);

    // Randomized groups against the reference model.
    for (int g = 0; g < 24; g++) begin
      int kind, base;
      kind = $urandom_range(0, 3);
      for (int i = 0; i < 4; i++) begin
        base = $urandom_range(0, 200);
        sr[i] = $urandom_range(0, 40000) % (base + 1) + 1000;
        sg[i] = $urandom_range(0, 40000) % (base + 1) + 1000;
        sb[i] = $urandom_range(0, 40000) % (base + 1) + 1000;
        case (kind)
          1: sr[i] += $urandom_range(0, 25000);
          2: sg[i] += $urandom_range(0, 25000);
          3: sb[i] += $urandom_range(0, 25000);
          default: ;
        endcase
      end
      run_group($urandom_range(0, 2), ($urandom_range(0, 7) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
